// File: rtl/reset_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// reset_seq_pkg : state encoding and reset-cause codes for reset_sequencer
// Rev 1.0
// ============================================================================
package reset_seq_pkg;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_STAGE = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_TRAP = 2'b10;

    // Domain index width; a single domain still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// reset_sync : STAGES-flop reset synchroniser, asynchronous assert,
//              synchronous deassert. Rev 1.0
// ============================================================================
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_o,
    output logic rst_next_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_o      = chain_q[STAGES-1];
    // Value rst_o takes after the next edge, so a consumer can act on that edge.
    assign rst_next_o = chain_q[STAGES-2];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// reset_sequencer : power-on hold, staggered domain release, software reset
//                   handshake and reset-cause register. Rev 1.0
//                   RST_TRAP_EN adds the trap port and trap-triggered reset.
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 3,
    parameter int CNT_W          = 16,
    parameter int POR_CYCLES     = 65535,
    parameter int SW_HOLD_CYCLES = 16,
    parameter int STEP_CYCLES    = 256,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw_rst_req,
`ifdef RST_TRAP_EN
    input  logic                 trap,
`endif
    output logic                 sw_rst_ack,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 rst_done,
    output logic [1:0]           rst_cause
);

    localparam int IDX_W = idx_width(N_DOMAINS);

    localparam logic [CNT_W-1:0] c_POR_LOAD  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SW_LOAD   = CNT_W'(SW_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(N_DOMAINS - 1);

    logic                 w_sync_rst;
    logic                 w_sync_next;
    logic                 w_sync_release;

    logic [1:0]           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                 done_q,    done_d;
    logic                 ack_q,     ack_d;
    logic [1:0]           cause_q,   cause_d;
`ifdef RST_TRAP_EN
    logic                 trap_q,    trap_d;
`endif

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_o      (w_sync_rst),
        .rst_next_o (w_sync_next)
    );

    // The hold starts on the same edge the synchronised reset drops.
    assign w_sync_release = w_sync_rst & ~w_sync_next;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        ack_d     = 1'b0;
        cause_d   = cause_q;
`ifdef RST_TRAP_EN
        trap_d    = (state_q == ST_RUN) && trap;
`endif

        case (state_q)
            ST_SYNC: begin
                if (w_sync_release) begin
                    state_d = ST_HOLD;
                    cnt_d   = c_POR_LOAD;
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    rst_out_d[0] = 1'b0;
                    cnt_d        = c_STEP_LOAD;
                    idx_d        = c_IDX_ONE;
                    if (N_DOMAINS == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_STAGE;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end

            ST_STAGE: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < N_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    cnt_d = c_STEP_LOAD;
                    idx_d = idx_q + c_IDX_ONE;
                    if (idx_q == c_LAST_IDX) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end

            ST_RUN: begin
                // A software request takes priority over a coincident trap.
                if (sw_rst_req) begin
                    state_d   = ST_HOLD;
                    cnt_d     = c_SW_LOAD;
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    ack_d     = 1'b1;
                    cause_d   = CAUSE_SW;
`ifdef RST_TRAP_EN
                end else if (trap && trap_q) begin
                    state_d   = ST_HOLD;
                    cnt_d     = c_SW_LOAD;
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    cause_d   = CAUSE_TRAP;
`endif
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            cause_q   <= CAUSE_EXT;
`ifdef RST_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            cause_q   <= cause_d;
`ifdef RST_TRAP_EN
            trap_q    <= trap_d;
`endif
        end
    end

    assign rst_out    = rst_out_q;
    assign rst_done   = done_q;
    assign sw_rst_ack = ack_q;
    assign rst_cause  = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_reset_sequencer : self-checking bench for reset_sequencer
// Rev 1.0
// ============================================================================
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int POR  = 10;
    localparam int STEP = 4;
    localparam int SWH  = 5;
    localparam int SS   = 2;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       trap       = 1'b0;
    logic       sw_rst_ack;
    logic       rst_done;
    logic [2:0] rst_out;
    logic [1:0] rst_cause;

    int n_cmp  = 0;
    int n_err  = 0;
    int edge_n = 0;

    reset_sequencer #(
        .N_DOMAINS      (N),
        .CNT_W          (16),
        .POR_CYCLES     (POR),
        .SW_HOLD_CYCLES (SWH),
        .STEP_CYCLES    (STEP),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
`ifdef RST_TRAP_EN
        .trap       (trap),
`endif
        .sw_rst_ack (sw_rst_ack),
        .rst_out    (rst_out),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    always #5 clk = ~clk;

    // Edge 1 is the first rising edge with reset low.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic wait_to(input int n);
        int g = 0;
        while (edge_n != n && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (edge_n != n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_to: reached edge %0d, required edge %0d", edge_n, n);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; sw_rst_req = 1'b0; trap = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Packed observation: {ack, cause[1:0], done, rst_out[2:0]}
    task automatic test_reset();
        sw_rst_req = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== 7'b0_00_0_111) begin
            n_err++;
            $display("FAIL reset_state: got %b required %b",
                     {sw_rst_ack, rst_cause, rst_done, rst_out}, 7'b0_00_0_111);
        end
        sw_rst_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_power_on();
        int         ev[7];
        logic [6:0] xv[7];
        ev = '{11, 12, 15, 16, 19, 20, 25};
        xv = '{7'b0_00_0_111, 7'b0_00_0_110, 7'b0_00_0_110, 7'b0_00_0_100,
               7'b0_00_0_100, 7'b0_00_1_000, 7'b0_00_1_000};
        for (int j = 0; j < 7; j++) begin
            wait_to(ev[j]);
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== xv[j]) begin
                n_err++;
                $display("FAIL power_on edge %0d: got %b required %b",
                         ev[j], {sw_rst_ack, rst_cause, rst_done, rst_out}, xv[j]);
            end
        end
    endtask

    task automatic test_sw_reset();
        int         ev[8];
        logic [6:0] xv[8];
        ev = '{30, 31, 34, 35, 38, 39, 42, 43};
        xv = '{7'b1_01_0_111, 7'b0_01_0_111, 7'b0_01_0_111, 7'b0_01_0_110,
               7'b0_01_0_110, 7'b0_01_0_100, 7'b0_01_0_100, 7'b0_01_1_000};
        wait_to(29);
        sw_rst_req = 1'b1;
        for (int j = 0; j < 8; j++) begin
            wait_to(ev[j]);
            sw_rst_req = 1'b0;
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== xv[j]) begin
                n_err++;
                $display("FAIL sw_reset edge %0d: got %b required %b",
                         ev[j], {sw_rst_ack, rst_cause, rst_done, rst_out}, xv[j]);
            end
        end
    endtask

    task automatic test_ignored_req();
        int         ev[5];
        logic [6:0] xv[5];
        ev = '{14, 15, 16, 19, 20};
        xv = '{7'b0_00_0_110, 7'b0_00_0_110, 7'b0_00_0_100, 7'b0_00_0_100,
               7'b0_00_1_000};
        apply_reset();
        wait_to(13);
        sw_rst_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_to(ev[j]);
            sw_rst_req = 1'b0;
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== xv[j]) begin
                n_err++;
                $display("FAIL ignored_req edge %0d: got %b required %b",
                         ev[j], {sw_rst_ack, rst_cause, rst_done, rst_out}, xv[j]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int         ev[5];
        logic [6:0] xv[5];
        ev = '{11, 12, 16, 19, 20};
        xv = '{7'b0_00_0_111, 7'b0_00_0_110, 7'b0_00_0_100, 7'b0_00_0_100,
               7'b0_00_1_000};
        apply_reset();
        wait_to(17);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({rst_done, rst_out} !== 4'b0_111) begin
            n_err++;
            $display("FAIL mid_reset_async: got %b required %b", {rst_done, rst_out}, 4'b0_111);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_to(ev[j]);
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== xv[j]) begin
                n_err++;
                $display("FAIL mid_reset_restart edge %0d: got %b required %b",
                         ev[j], {sw_rst_ack, rst_cause, rst_done, rst_out}, xv[j]);
            end
        end
    endtask

`ifdef RST_TRAP_EN
    task automatic test_trap();
        int         ev[6];
        logic [6:0] xv[6];
        ev = '{30, 31, 35, 36, 40, 44};
        xv = '{7'b0_00_1_000, 7'b0_10_0_111, 7'b0_10_0_111, 7'b0_10_0_110,
               7'b0_10_0_100, 7'b0_10_1_000};
        apply_reset();
        wait_to(29);
        trap = 1'b1;
        for (int j = 0; j < 6; j++) begin
            wait_to(ev[j]);
            if (ev[j] >= 31) trap = 1'b0;
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== xv[j]) begin
                n_err++;
                $display("FAIL trap edge %0d: got %b required %b",
                         ev[j], {sw_rst_ack, rst_cause, rst_done, rst_out}, xv[j]);
            end
        end
    endtask

    task automatic test_single_trap();
        apply_reset();
        wait_to(29);
        trap = 1'b1;
        for (int e = 30; e <= 33; e++) begin
            wait_to(e);
            trap = 1'b0;
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== 7'b0_00_1_000) begin
                n_err++;
                $display("FAIL single_trap edge %0d: got %b required %b",
                         e, {sw_rst_ack, rst_cause, rst_done, rst_out}, 7'b0_00_1_000);
            end
        end
    endtask

    task automatic test_collision();
        int         ev[4];
        logic [6:0] xv[4];
        ev = '{30, 31, 32, 36};
        xv = '{7'b0_00_1_000, 7'b1_01_0_111, 7'b0_01_0_111, 7'b0_01_0_110};
        apply_reset();
        wait_to(29);
        trap = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_to(ev[j]);
            sw_rst_req = (ev[j] == 30);
            if (ev[j] >= 31) trap = 1'b0;
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== xv[j]) begin
                n_err++;
                $display("FAIL collision edge %0d: got %b required %b",
                         ev[j], {sw_rst_ack, rst_cause, rst_done, rst_out}, xv[j]);
            end
        end
    endtask
`endif

    // Reference: each domain i is in reset while e < start + hold + i*STEP.
    task automatic test_random();
        int         s      = SS;
        int         hh     = POR;
        int         ack_e  = -1;
        logic [1:0] cause  = 2'b00;
        bit         prev_tr = 1'b0;
        bit         in_run, nreq, ntrap;
        int         e;
        logic [2:0] x_out;
        logic       x_done;
        logic       x_ack;
        apply_reset();
        for (int c = 0; c < 700; c++) begin
            e = edge_n;
            for (int i = 0; i < N; i++) x_out[i] = (e < s + hh + i * STEP);
            x_done = (e >= s + hh + (N - 1) * STEP);
            x_ack  = (e == ack_e);
            n_cmp++;
            if ({sw_rst_ack, rst_cause, rst_done, rst_out} !== {x_ack, cause, x_done, x_out}) begin
                n_err++;
                $display("FAIL random edge %0d: got %b required %b", e,
                         {sw_rst_ack, rst_cause, rst_done, rst_out}, {x_ack, cause, x_done, x_out});
            end
            in_run = x_done;
            nreq   = !sw_rst_req && ($urandom_range(0, 29) == 0);
`ifdef RST_TRAP_EN
            ntrap  = trap ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
`else
            ntrap  = 1'b0;
`endif
            sw_rst_req = nreq;
            trap       = ntrap;
            if (nreq && in_run) begin
                s = e + 1; hh = SWH; cause = 2'b01; ack_e = e + 1;
            end else if (ntrap && in_run && prev_tr) begin
                s = e + 1; hh = SWH; cause = 2'b10;
            end
            prev_tr = ntrap && in_run;
            @(negedge clk);
        end
        sw_rst_req = 1'b0;
        trap       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_sw_reset();
        test_ignored_req();
        test_mid_reset();
`ifdef RST_TRAP_EN
        test_trap();
        test_single_trap();
        test_collision();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
